activ4_seq: RTL and testbench
=============================

# activ4_seq

Sequencer for the Activity 4 state-diagram FSM. It accepts a command holding a pattern of x/y input bits and a target state. It then resets the FSM and applies one x/y pair per clock while monitoring the FSM's current state. It reports whether and after how many bits the FSM reached the target. It sits between the lab top level (or bench) and the FSM instance, owning the FSM's reset and inputs.

## Interface
- LEN, 8, maximum pattern length in bits (≥1)
- CNT_W, $clog2(LEN+1), width of length/step fields
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  command valid; accepted only when ready=1
- ready  out  1  high in IDLE only
- pat_x  in  LEN  x bits; bit i applied at step i
- pat_y  in  LEN  y bits; bit i applied at step i
- pat_len  in  CNT_W  bits to apply, 0..LEN; values >LEN are clamped to LEN
- target_state  in  3  state code to detect
- fsm_state  in  3  FSM currentState
- fsm_reset  out  1  active-high reset to FSM
- fsm_x  out  1  FSM x input
- fsm_y  out  1  FSM y input
- busy  out  1  high in RST, DRIVE, CHECK
- done  out  1  one-cycle pulse in DONE
- hit  out  1  target seen during the last command
- hit_step  out  CNT_W  bits applied when the target was first seen

## Operation
- States: IDLE, RST, DRIVE, CHECK, DONE. All outputs are registered.
- IDLE:
  - ready=1.
  - When start=1, latch pat_x, pat_y, clamped pat_len and target_state, clear hit/hit_step, then go to RST.
- RST: fsm_reset=1 for exactly one cycle, step counter i=0, then DRIVE. If pat_len=0, go to CHECK instead.
- DRIVE:
  - fsm_x=pat_x[i] and fsm_y=pat_y[i]. Compare fsm_state against the target.
  - At step i, fsm_state reflects i bits applied. Step 0 is the FSM reset state.
  - i increments each cycle. After step len-1, go to CHECK.
- CHECK: compare fsm_state (len bits applied), then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Compare rule: the first cycle with fsm_state==target while hit=0 sets hit=1 and hit_step = bits applied (i in DRIVE, len in CHECK). Later matches are ignored.
- hit and hit_step hold their values from completion until the next accepted start.
- fsm_x and fsm_y are 0 outside DRIVE. fsm_reset is 0 outside RST.
- start while busy is ignored, with no queueing.
- If start is asserted in the DONE cycle, it is ignored. It may be accepted on the following IDLE cycle.

## Timing
- reset=0 at a clock edge forces IDLE from any state. All counters are cleared.
- After reset, outputs are: ready=1, busy=0, done=0, hit=0, hit_step=0, fsm_reset=0, fsm_x=0, fsm_y=0.
- Reset mid-command abandons the command. No done pulse is produced.
- Start accepted at edge 0:
  - RST occupies cycle 1.
  - DRIVE step i occupies cycle 2+i.
  - CHECK occupies cycle 2+L.
  - DONE occupies cycle 3+L.
  - ready returns in cycle 4+L.
- Start-to-done latency is L+3 cycles. For L=0 it is 3 cycles (RST, CHECK, DONE).
- Step counter width is CNT_W. No wrap occurs because i never exceeds LEN.

## Configuration
- ACTIV4_SEQ_EARLY_STOP_EN defined:
  - A hit in DRIVE step k moves the FSM directly to DONE in the next cycle, skipping the remaining steps and CHECK. done occurs in cycle 3+k.
  - A hit in CHECK behaves as without the macro.
- Undefined: the full pattern is always applied. Latency is fixed at L+3. hit and hit_step still record the first match.

## Test plan
- Bench stubs fsm_state; reset held low 2 cycles → ready=1, all other outputs 0; releasing reset keeps IDLE.
- Command: pat_len=4, pat_x=4'b1010, pat_y=4'b0110, target=3'd5, fsm_state held at 0.
  - fsm_reset=1 in cycle 1.
  - (fsm_x,fsm_y) = (0,0),(1,1),(0,1),(1,0) in cycles 2–5.
  - done in cycle 7, hit=0.
- Same command with fsm_state=5 from cycle 4 onward:
  - Undefined macro: hit=1, hit_step=2, done in cycle 7.
  - With ACTIV4_SEQ_EARLY_STOP_EN: done in cycle 5.
- Zero and oversized length:
  - pat_len=0, target=0, fsm_state=0 → RST, CHECK, DONE; done in cycle 3, hit=1, hit_step=0.
  - pat_len=LEN+3 → clamped; done in cycle LEN+3.
- start pulses during busy and in the DONE cycle are ignored; the next start is accepted only when ready=1, and hit from the prior command clears on acceptance.
- reset=0 during DRIVE step 2 → next cycle IDLE, fsm_x=0, no done; a new command afterwards runs normally.

Source files
------------

// File: rtl/activ4_seq.sv
// Sequencer for the Activity 4 FSM: resets the FSM, plays an x/y bit pattern into it and
// records when its state first matches a target. Define ACTIV4_SEQ_EARLY_STOP_EN to end a command on a DRIVE hit.
module activ4_seq #(
  parameter int LEN   = 8,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [LEN-1:0]   pat_x,
  input  logic [LEN-1:0]   pat_y,
  input  logic [CNT_W-1:0] pat_len,
  input  logic [2:0]       target_state,
  input  logic [2:0]       fsm_state,
  output logic             fsm_reset,
  output logic             fsm_x,
  output logic             fsm_y,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] hit_step
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] step, step_n;
  logic             hit_n;
  logic [CNT_W-1:0] hit_step_n;
  logic             load;
  logic             match;
  logic [CNT_W-1:0] len_clamp;
  logic [CNT_W-1:0] len_last;

  logic [LEN-1:0]   px_q;
  logic [LEN-1:0]   py_q;
  logic [CNT_W-1:0] len_q;
  logic [2:0]       tgt_q;

  logic ready_n, busy_n, done_n, fsm_reset_n, fsm_x_n, fsm_y_n;

  always_comb begin
    len_clamp = (pat_len > CNT_W'(LEN)) ? CNT_W'(LEN) : pat_len;
    len_last  = len_q - CNT_W'(1);
    match     = (fsm_state == tgt_q) && !hit;
  end

  always_comb begin
    state_n    = state;
    step_n     = step;
    hit_n      = hit;
    hit_step_n = hit_step;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          hit_n      = 1'b0;
          hit_step_n = '0;
          step_n     = '0;
          state_n    = S_RST;
        end
      end
      S_RST: begin
        step_n  = '0;
        state_n = (len_q == '0) ? S_CHECK : S_DRIVE;
      end
      S_DRIVE: begin
        // fsm_state here reflects exactly 'step' bits already applied
        if (match) begin
          hit_n      = 1'b1;
          hit_step_n = step;
        end
        if (step == len_last) begin
          state_n = S_CHECK;
        end else begin
          step_n = step + CNT_W'(1);
        end
`ifdef ACTIV4_SEQ_EARLY_STOP_EN
        if (match) begin
          state_n = S_DONE;
        end
`endif
      end
      S_CHECK: begin
        if (match) begin
          hit_n      = 1'b1;
          hit_step_n = len_q;
        end
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_comb begin
    ready_n     = (state_n == S_IDLE);
    busy_n      = (state_n == S_RST) || (state_n == S_DRIVE) || (state_n == S_CHECK);
    done_n      = (state_n == S_DONE);
    fsm_reset_n = (state_n == S_RST);
    fsm_x_n     = 1'b0;
    fsm_y_n     = 1'b0;
    if (state_n == S_DRIVE) begin
      for (int k = 0; k < LEN; k++) begin
        if (step_n == CNT_W'(k)) begin
          fsm_x_n = px_q[k];
          fsm_y_n = py_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      step      <= '0;
      hit       <= 1'b0;
      hit_step  <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      fsm_reset <= 1'b0;
      fsm_x     <= 1'b0;
      fsm_y     <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      hit       <= hit_n;
      hit_step  <= hit_step_n;
      ready     <= ready_n;
      busy      <= busy_n;
      done      <= done_n;
      fsm_reset <= fsm_reset_n;
      fsm_x     <= fsm_x_n;
      fsm_y     <= fsm_y_n;
    end
  end

  // Command fields are plain data: captured on acceptance, never reset
  always_ff @(posedge clk) begin
    if (load) begin
      px_q  <= pat_x;
      py_q  <= pat_y;
      len_q <= len_clamp;
      tgt_q <= target_state;
    end
  end

endmodule

// File: tb/tb_activ4_seq.sv
// Scoreboard bench for activ4_seq: a stub drives fsm_state per step, a reference model
// predicts the command outcome, and a monitor checks each done pulse against it.
module tb_activ4_seq;

  localparam int LEN   = 8;
  localparam int CNT_W = $clog2(LEN + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             ready;
  logic [LEN-1:0]   pat_x;
  logic [LEN-1:0]   pat_y;
  logic [CNT_W-1:0] pat_len;
  logic [2:0]       target_state;
  logic [2:0]       fsm_state;
  logic             fsm_reset;
  logic             fsm_x;
  logic             fsm_y;
  logic             busy;
  logic             done;
  logic             hit;
  logic [CNT_W-1:0] hit_step;

  activ4_seq #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .pat_x(pat_x), .pat_y(pat_y), .pat_len(pat_len), .target_state(target_state),
    .fsm_state(fsm_state), .fsm_reset(fsm_reset), .fsm_x(fsm_x), .fsm_y(fsm_y),
    .busy(busy), .done(done), .hit(hit), .hit_step(hit_step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int             dc;
    bit             hit;
    int             hs;
    logic [LEN-1:0] xv;
    logic [LEN-1:0] yv;
  } exp_t;

  exp_t sbq[$];
  int   st[LEN+1];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // FSM state after k applied bits is st[k]; first match wins, done follows the schedule
  function automatic exp_t model(logic [LEN-1:0] x, logic [LEN-1:0] y, int len, int tgt);
    exp_t e;
    int L;
    int n;
    logic [LEN-1:0] m;
    L = (len > LEN) ? LEN : len;
    e.hit = 1'b0;
    e.hs  = 0;
    for (int k = 0; k <= L; k++) begin
      if (!e.hit && st[k] == tgt) begin
        e.hit = 1'b1;
        e.hs  = k;
      end
    end
    n    = L;
    e.dc = 3 + L;
`ifdef ACTIV4_SEQ_EARLY_STOP_EN
    if (e.hit && e.hs < L) begin
      n    = e.hs + 1;
      e.dc = 3 + e.hs;
    end
`endif
    m = '0;
    for (int k = 0; k < n; k++) m[k] = 1'b1;
    e.xv = x & m;
    e.yv = y & m;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [LEN-1:0] x, input logic [LEN-1:0] y,
                         input int len, input int tgt, input bit noise);
    exp_t e;
    int   L;
    int   idx;
    int   w;
    w = 0;
    while (!ready && w < 50) begin
      tick();
      w++;
    end
    if (!ready) begin
      chk("ready_wait", int'(ready), 1);
      return;
    end
    L = (len > LEN) ? LEN : len;
    e = model(x, y, len, tgt);
    sbq.push_back(e);
    start        = 1'b1;
    pat_x        = x;
    pat_y        = y;
    pat_len      = CNT_W'(len);
    target_state = 3'(tgt);
    tick();
    for (int c = 1; c <= e.dc; c++) begin
      idx = c - 2;
      if (idx < 0) idx = 0;
      if (idx > L) idx = L;
      fsm_state = 3'(st[idx]);
      start = noise && ((c == e.dc) || ($urandom_range(0, 3) == 0));
      if (start) begin
        pat_x        = LEN'($urandom);
        pat_y        = LEN'($urandom);
        pat_len      = CNT_W'($urandom_range(0, 15));
        target_state = 3'($urandom_range(0, 7));
      end
      tick();
    end
    start = 1'b0;
  endtask

  // Monitor: follows each command from its fsm_reset pulse to its done pulse
  bit             trk = 1'b0;
  int             mc  = 0;
  logic [LEN-1:0] mxv;
  logic [LEN-1:0] myv;
  exp_t           me;

  always @(negedge clk) begin
    if (!reset) begin
      trk = 1'b0;
    end else begin
      if (fsm_reset) begin
        trk = 1'b1;
        mc  = 1;
        mxv = '0;
        myv = '0;
        chk("hit_clear_on_accept", int'(hit), 0);
        chk("hit_step_clear_on_accept", int'(hit_step), 0);
      end else if (trk) begin
        mc++;
        if (mc >= 2 && mc - 2 < LEN) begin
          mxv[mc-2] = fsm_x;
          myv[mc-2] = fsm_y;
        end
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          me = sbq.pop_front();
          chk("done_cycle", mc, me.dc);
          chk("hit", int'(hit), int'(me.hit));
          chk("hit_step", int'(hit_step), me.hs);
          chk("x_pattern", int'(mxv), int'(me.xv));
          chk("y_pattern", int'(myv), int'(me.yv));
          chk("busy_in_done", int'(busy), 0);
          chk("ready_in_done", int'(ready), 0);
        end
        trk = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset        = 1'b0;
    start        = 1'b0;
    pat_x        = '0;
    pat_y        = '0;
    pat_len      = '0;
    target_state = '0;
    fsm_state    = '0;
    tick();
    tick();
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_step", int'(hit_step), 0);
    chk("rst_fsm_reset", int'(fsm_reset), 0);
    chk("rst_fsm_x", int'(fsm_x), 0);
    chk("rst_fsm_y", int'(fsm_y), 0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_ready", int'(ready), 1);
    chk("idle_busy", int'(busy), 0);

    // Directed: no match, then a match from step 2, zero and oversized lengths
    for (int k = 0; k <= LEN; k++) st[k] = 0;
    run_cmd(8'b0000_1010, 8'b0000_0110, 4, 5, 1'b0);
    for (int k = 0; k <= LEN; k++) st[k] = (k >= 2) ? 5 : 0;
    run_cmd(8'b0000_1010, 8'b0000_0110, 4, 5, 1'b0);
    for (int k = 0; k <= LEN; k++) st[k] = 0;
    run_cmd(8'hA5, 8'h3C, 0, 0, 1'b0);
    for (int k = 0; k <= LEN; k++) st[k] = 1;
    run_cmd(8'hC3, 8'h5A, LEN + 3, 6, 1'b1);

    // Randomized commands with spurious start pulses while busy and in DONE
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k <= LEN; k++) st[k] = $urandom_range(0, 5);
      run_cmd(LEN'($urandom), LEN'($urandom), $urandom_range(0, 15),
              $urandom_range(0, 5), n[0]);
    end

    // Reset during DRIVE step 2 abandons the command
    w = 0;
    while (!ready && w < 50) begin
      tick();
      w++;
    end
    for (int k = 0; k <= LEN; k++) st[k] = 1;
    fsm_state    = 3'd1;
    start        = 1'b1;
    pat_x        = 8'hFF;
    pat_y        = 8'hFF;
    pat_len      = CNT_W'(6);
    target_state = 3'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_fsm_x", int'(fsm_x), 1);
    reset = 1'b0;
    tick();
    chk("abort_ready", int'(ready), 1);
    chk("abort_fsm_x", int'(fsm_x), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) tick();

    for (int k = 0; k <= LEN; k++) st[k] = (k == 3) ? 2 : 4;
    run_cmd(8'h6B, 8'h91, 5, 2, 1'b0);

    w = 0;
    while (sbq.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
